// File: rtl/stream_pkg.sv
// Shared definitions for the two-way stream demultiplexer.
//   state_t  : packet-tracking FSM states (IDLE / PKT_A / PKT_B)
//   ROUTE_A / ROUTE_B : route encoding used by the top level
//   route_of : maps the two select bits to a route
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT_A = 2'd1,
        PKT_B = 2'd2
    } state_t;

    localparam logic ROUTE_A = 1'b0;
    localparam logic ROUTE_B = 1'b1;

    // Port B only when both select bits are set; every other pattern goes to A.
    function automatic logic route_of(input logic sel_b1, input logic sel_b2);
        return (sel_b1 && sel_b2) ? ROUTE_B : ROUTE_A;
    endfunction

endpackage

// File: rtl/stream_slice.sv
// One-entry register slice for a valid/ready stream.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : write data_i into the slice this cycle (caller guarantees space_o)
//   data_i         : payload to store
//   ready_i        : downstream sink ready
//   valid_o        : slice holds a beat
//   data_o         : held payload (cleared to 0 on reset, kept after drain)
//   space_o        : slice can take a beat this cycle (empty, or draining now)
module stream_slice #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         space_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    // Full-and-draining counts as space so a stream can run at one beat per cycle.
    assign space_o = !valid_q || ready_i;

endmodule

// File: rtl/stream_demux2.sv
// Two-way packet stream demultiplexer. A packet's route is chosen from
// sel_b1/sel_b2 on its first beat and held until its last beat; each output
// port sits behind a one-entry register slice (1-cycle latency).
// Handshake: on every port a beat moves when valid & ready are both high in
// the same cycle; a source holding valid keeps data/last stable until then.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready : upstream stream
//   sel_b1, sel_b2                  : route select (B only when both are 1)
//   a_data/a_valid/a_last/a_ready   : port A stream
//   b_data/b_valid/b_last/b_ready   : port B stream
//   pkt_cnt_a, pkt_cnt_b            : completed packets per port (wrap at 256)
//   busy                            : a packet is in progress
//   state_dbg                       : current FSM state (stream_pkg::state_t)
module stream_demux2
    import stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             sel_b1,
    input  logic             sel_b2,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    output logic             a_last,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    output logic             b_last,
    input  logic             b_ready,
    output logic [7:0]       pkt_cnt_a,
    output logic [7:0]       pkt_cnt_b,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    state_t     state_q;
    logic [7:0] cnt_a_q, cnt_b_q;
    logic       route_cur;
    logic       a_space, b_space;
    logic       xfer;
    logic       load_a, load_b;

    // In IDLE the incoming beat starts a packet, so the live select decides;
    // mid-packet the state itself carries the latched route.
    always_comb begin
        route_cur = ROUTE_A;
        case (state_q)
            IDLE:    route_cur = route_of(sel_b1, sel_b2);
            PKT_B:   route_cur = ROUTE_B;
            default: route_cur = ROUTE_A;
        endcase
    end

    // Depends only on state, select and the sink side, never on in_valid.
    assign in_ready = !reset && ((route_cur == ROUTE_B) ? b_space : a_space);
    assign xfer     = in_valid && in_ready;
    assign load_a   = xfer && (route_cur == ROUTE_A);
    assign load_b   = xfer && (route_cur == ROUTE_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_a_q <= 8'd0;
            cnt_b_q <= 8'd0;
        end else if (xfer) begin
            if (in_last) begin
                state_q <= IDLE;
                if (route_cur == ROUTE_B) cnt_b_q <= cnt_b_q + 8'd1;
                else                      cnt_a_q <= cnt_a_q + 8'd1;
            end else begin
                state_q <= (route_cur == ROUTE_B) ? PKT_B : PKT_A;
            end
        end
    end

    stream_slice #(.W(WIDTH + 1)) u_slice_a (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (load_a),
        .data_i  ({in_last, in_data}),
        .ready_i (a_ready),
        .valid_o (a_valid),
        .data_o  ({a_last, a_data}),
        .space_o (a_space)
    );

    stream_slice #(.W(WIDTH + 1)) u_slice_b (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (load_b),
        .data_i  ({in_last, in_data}),
        .ready_i (b_ready),
        .valid_o (b_valid),
        .data_o  ({b_last, b_data}),
        .space_o (b_space)
    );

    assign pkt_cnt_a = cnt_a_q;
    assign pkt_cnt_b = cnt_b_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stream_demux2.sv
// Bench for stream_demux2: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a queue-based model.
module tb_stream_demux2;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid, in_last, in_ready;
    logic         sel_b1, sel_b2;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, a_last, a_ready;
    logic         b_valid, b_last, b_ready;
    logic [7:0]   pkt_cnt_a, pkt_cnt_b;
    logic         busy;
    logic [1:0]   state_dbg;

    stream_demux2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sel_b1    (sel_b1),
        .sel_b2    (sel_b2),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .pkt_cnt_a (pkt_cnt_a),
        .pkt_cnt_b (pkt_cnt_b),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    logic [W:0] exp_qa[$];     // {last, data} beats owed on port A
    logic [W:0] exp_qb[$];
    logic       m_init = 1'b0; // outputs meaningful only after the first reset
    logic       m_open;        // a packet has started and not ended
    logic       m_route;       // 1 = B, for the open packet
    logic [7:0] m_ca, m_cb;

    // values captured in the last cycle, used by directed checks
    logic         s_ir, s_av, s_al, s_bv, s_bl, s_busy, s_xfer;
    logic [W-1:0] s_ad, s_bd;
    logic [7:0]   s_ca, s_cb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic r, input logic s1, input logic s2, input logic v,
                         input logic [W-1:0] d, input logic l, input logic ar, input logic br);
        logic route_now, exp_ir, xin;
        @(negedge clk);
        reset = r; sel_b1 = s1; sel_b2 = s2; in_valid = v; in_data = d; in_last = l;
        a_ready = ar; b_ready = br;
        #1;
        s_ir = in_ready; s_av = a_valid; s_ad = a_data; s_al = a_last;
        s_bv = b_valid; s_bd = b_data; s_bl = b_last; s_busy = busy;
        s_ca = pkt_cnt_a; s_cb = pkt_cnt_b;

        route_now = m_open ? m_route : (s1 & s2);
        exp_ir = r ? 1'b0 : (route_now ? (exp_qb.size() == 0 || br) : (exp_qa.size() == 0 || ar));
        xin = 1'b0;
        if (m_init) begin
            chk("in_ready", in_ready, exp_ir);
            chk("a_valid", a_valid, exp_qa.size() != 0);
            chk("b_valid", b_valid, exp_qb.size() != 0);
            if (a_valid && exp_qa.size() != 0) begin
                chk("a_data", a_data, exp_qa[0][W-1:0]);
                chk("a_last", a_last, exp_qa[0][W]);
            end
            if (b_valid && exp_qb.size() != 0) begin
                chk("b_data", b_data, exp_qb[0][W-1:0]);
                chk("b_last", b_last, exp_qb[0][W]);
            end
            chk("busy", busy, m_open);
            chk("pkt_cnt_a", pkt_cnt_a, m_ca);
            chk("pkt_cnt_b", pkt_cnt_b, m_cb);
        end else begin
            chk("in_ready_rst", in_ready, exp_ir);
        end

        if (r) begin
            exp_qa.delete(); exp_qb.delete();
            m_open = 1'b0; m_route = 1'b0; m_ca = 8'd0; m_cb = 8'd0; m_init = 1'b1;
        end else if (m_init) begin
            if (a_valid && ar && exp_qa.size() != 0) void'(exp_qa.pop_front());
            if (b_valid && br && exp_qb.size() != 0) void'(exp_qb.pop_front());
            xin = v && in_ready;
            if (xin) begin
                if (route_now) exp_qb.push_back({l, d});
                else           exp_qa.push_back({l, d});
                if (l) begin
                    m_open = 1'b0;
                    if (route_now) m_cb++;
                    else           m_ca++;
                end else begin
                    m_open  = 1'b1;
                    m_route = route_now;
                end
            end
        end
        s_xfer = xin;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic s1, s2, v;
        logic [W-1:0] d;
        logic l, ar, br;
        logic e_ir, e_av;
        logic [W-1:0] e_ad;
        logic e_al, e_bv;
        logic [W-1:0] e_bd;
        logic e_bl, e_busy;
        logic [7:0] e_ca, e_cb;
    } vec_t;

    vec_t vecs[11];

    // watchdog: the run is fixed-length, this only guards against a stalled sim
    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] base_a, base_b;
        logic       p_v, p_l, rr, s1, s2;
        logic [W-1:0] p_d;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        sel_b1 = 1'b0; sel_b2 = 1'b0; a_ready = 1'b0; b_ready = 1'b0;

        // reset: in_ready low during reset, everything cleared afterwards
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("rst_in_ready", s_ir, 1'b0);
        idle_cycle();
        chk("rst_a_valid", s_av, 1'b0);
        chk("rst_b_valid", s_bv, 1'b0);
        chk("rst_a_last", s_al, 1'b0);
        chk("rst_b_last", s_bl, 1'b0);
        chk("rst_a_data", s_ad, 8'h00);
        chk("rst_b_data", s_bd, 8'h00);
        chk("rst_cnt_a", s_ca, 8'd0);
        chk("rst_cnt_b", s_cb, 8'd0);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_state", state_dbg, 2'd0);

        // sel=11 three-beat packet to B, then sel=10 then 11 four-beat packet to A
        //           s1 s2 v  d      l  ar br  ir av ad     al bv bd     bl busy ca cb
        vecs[0]  = '{1, 1, 1, 8'h11, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 8'h22, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'h11, 0, 1, 0, 0};
        vecs[2]  = '{1, 1, 1, 8'h33, 1, 1, 1,  1, 0, 8'h00, 0, 1, 8'h22, 0, 1, 0, 0};
        vecs[3]  = '{1, 1, 0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 1, 8'h33, 1, 0, 0, 1};
        vecs[4]  = '{1, 1, 0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[5]  = '{1, 0, 1, 8'hA1, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 1, 8'hA2, 0, 1, 1,  1, 1, 8'hA1, 0, 0, 8'h00, 0, 1, 0, 1};
        vecs[7]  = '{1, 1, 1, 8'hA3, 0, 1, 1,  1, 1, 8'hA2, 0, 0, 8'h00, 0, 1, 0, 1};
        vecs[8]  = '{1, 1, 1, 8'hA4, 1, 1, 1,  1, 1, 8'hA3, 0, 0, 8'h00, 0, 1, 0, 1};
        vecs[9]  = '{1, 1, 0, 8'h00, 0, 1, 1,  1, 1, 8'hA4, 1, 0, 8'h00, 0, 0, 1, 1};
        vecs[10] = '{1, 1, 0, 8'h00, 0, 1, 1,  1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 1};

        for (int i = 0; i < 11; i++) begin
            cycle(1'b0, vecs[i].s1, vecs[i].s2, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].ar, vecs[i].br);
            chk($sformatf("tbl%0d_ir", i), s_ir, vecs[i].e_ir);
            chk($sformatf("tbl%0d_av", i), s_av, vecs[i].e_av);
            chk($sformatf("tbl%0d_bv", i), s_bv, vecs[i].e_bv);
            if (vecs[i].e_av) begin
                chk($sformatf("tbl%0d_ad", i), s_ad, vecs[i].e_ad);
                chk($sformatf("tbl%0d_al", i), s_al, vecs[i].e_al);
            end
            if (vecs[i].e_bv) begin
                chk($sformatf("tbl%0d_bd", i), s_bd, vecs[i].e_bd);
                chk($sformatf("tbl%0d_bl", i), s_bl, vecs[i].e_bl);
            end
            chk($sformatf("tbl%0d_busy", i), s_busy, vecs[i].e_busy);
            chk($sformatf("tbl%0d_ca", i), s_ca, vecs[i].e_ca);
            chk($sformatf("tbl%0d_cb", i), s_cb, vecs[i].e_cb);
        end

        // backpressure on A: slice fills, in_ready drops, data held, nothing lost
        base_a = pkt_cnt_a;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h51, 1'b0, 1'b0, 1'b1);
        chk("bp_ir_first", s_ir, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h52, 1'b0, 1'b0, 1'b1);
            chk("bp_ir_low", s_ir, 1'b0);
            chk("bp_a_hold", s_ad, 8'h51);
            chk("bp_a_valid", s_av, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h52, 1'b0, 1'b1, 1'b1);
        chk("bp_ir_resume", s_ir, 1'b1);
        chk("bp_a_51", s_ad, 8'h51);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h53, 1'b1, 1'b1, 1'b1);
        chk("bp_a_52", s_ad, 8'h52);
        idle_cycle();
        chk("bp_a_53", s_ad, 8'h53);
        chk("bp_a_53_last", s_al, 1'b1);
        idle_cycle();
        chk("bp_a_empty", s_av, 1'b0);
        chk("bp_cnt_a", s_ca, 8'(base_a + 8'd1));

        // single-beat packets alternating B/A at full rate
        base_a = pkt_cnt_a; base_b = pkt_cnt_b;
        for (int k = 0; k < 10; k++) begin
            s1 = (k % 2 == 0);
            cycle(1'b0, s1, s1, 1'b1, 8'(8'h80 + k), 1'b1, 1'b1, 1'b1);
            chk("alt_ir", s_ir, 1'b1);
            chk("alt_busy", s_busy, 1'b0);
        end
        idle_cycle();
        idle_cycle();
        chk("alt_cnt_a", s_ca, 8'(base_a + 8'd5));
        chk("alt_cnt_b", s_cb, 8'(base_b + 8'd5));

        // reset in the middle of a packet to A; next packet follows fresh sel
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h61, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h62, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_ir", s_ir, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_av", s_av, 1'b0);
        chk("mid_rst_bv", s_bv, 1'b0);
        chk("mid_rst_ca", s_ca, 8'd0);
        chk("mid_rst_cb", s_cb, 8'd0);
        chk("mid_rst_busy", s_busy, 1'b0);
        chk("mid_rst_state", state_dbg, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h71, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h72, 1'b1, 1'b1, 1'b1);
        chk("post_rst_b71", s_bd, 8'h71);
        chk("post_rst_bv", s_bv, 1'b1);
        idle_cycle();
        chk("post_rst_b72", s_bd, 8'h72);
        chk("post_rst_av", s_av, 1'b0);
        idle_cycle();
        chk("post_rst_cb", s_cb, 8'd1);
        chk("post_rst_ca", s_ca, 8'd0);

        // 256 single-beat packets to A: counter wraps to 0
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 256; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'(k), 1'b1, 1'b1, 1'b1);
            if (k == 255) chk("wrap_255", s_ca, 8'd255);
        end
        idle_cycle();
        chk("wrap_0", s_ca, 8'd0);

        // randomized traffic against the model
        p_v = 1'b0; p_d = '0; p_l = 1'b0; rr = 1'b0; s_xfer = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!p_v || s_xfer || rr) begin
                p_v = ($urandom_range(0, 3) != 0);
                p_d = 8'($urandom);
                p_l = ($urandom_range(0, 2) == 0);
            end
            rr = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 1) == 1) begin
                s1 = 1'b1; s2 = 1'b1;
            end else begin
                s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
            end
            cycle(rr, s1, s2, p_v, p_d, p_l,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) idle_cycle();
        chk("drain_a", exp_qa.size(), 0);
        chk("drain_b", exp_qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
